// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared car state type, default timing constants and floor-vector helpers
// Floor helpers work on a zero-extended vector so one function serves any NUM_FLOORS up to MAX_FLOORS.
package elevator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DWELL = 2'd2
  } car_state_t;

  localparam int DEF_NUM_FLOORS  = 6;
  localparam int DEF_STEP_TICKS  = 30;
  localparam int DEF_DWELL_TICKS = 5;
  localparam int MAX_FLOORS      = 64;

  typedef logic [MAX_FLOORS-1:0] floor_vec_t;

  function automatic logic any_above(input floor_vec_t trig, input int fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i > fl) && trig[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic any_below(input floor_vec_t trig, input int fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if ((i < fl) && trig[i]) r = 1'b1;
    end
    return r;
  endfunction

  function automatic logic at_floor(input floor_vec_t trig, input int fl);
    logic r;
    r = 1'b0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i == fl) r = trig[i];
    end
    return r;
  endfunction

  function automatic floor_vec_t floor_onehot(input int fl);
    floor_vec_t r;
    r = '0;
    for (int i = 0; i < MAX_FLOORS; i++) begin
      if (i == fl) r[i] = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/elevator_car_fsm.sv
// rtl/elevator_car_fsm.sv - one elevator car: SCAN FSM, shared step/dwell timer, half-floor position
// Every output is a flop updated from the next-state logic, so outputs track the state register exactly.
module elevator_car_fsm
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int STEP_TICKS  = DEF_STEP_TICKS,
  parameter int DWELL_TICKS = DEF_DWELL_TICKS,
  localparam int POS_W      = $clog2(2*NUM_FLOORS-1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_tick_en,
  input  logic [NUM_FLOORS-1:0] i_trig,
  input  logic                  i_door_hold,
  output logic [POS_W-1:0]      o_half_pos,
  output logic                  o_dir_up,
  output logic                  o_moving,
  output logic                  o_door_open,
  output logic [NUM_FLOORS-1:0] o_served
);

  localparam int TMR_MAX = (STEP_TICKS > DWELL_TICKS) ? STEP_TICKS : DWELL_TICKS;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [POS_W-1:0] MAX_POS    = POS_W'(2*(NUM_FLOORS-1));
  localparam logic [TMR_W-1:0] STEP_LAST  = TMR_W'(STEP_TICKS-1);
  localparam logic [TMR_W-1:0] DWELL_LAST = TMR_W'(DWELL_TICKS-1);

  car_state_t            r_state, w_state_nxt;
  logic [TMR_W-1:0]      r_timer, w_timer_nxt;
  logic [POS_W-1:0]      r_pos, w_pos_nxt, w_pos_step;
  logic                  r_dir, w_dir_nxt;
  logic                  r_moving, r_door;
  logic [NUM_FLOORS-1:0] r_served, w_served_nxt;

  floor_vec_t w_trig;
  int         w_fl, w_fl_step;
  logic       w_here, w_above, w_below;
  logic       w_hit_step, w_above_step, w_below_step;

  assign w_trig     = floor_vec_t'(i_trig);
  assign w_pos_step = r_dir ? (r_pos + 1'b1) : (r_pos - 1'b1);
  assign w_fl       = int'(r_pos >> 1);
  assign w_fl_step  = int'(w_pos_step >> 1);

  assign w_here       = at_floor(w_trig, w_fl);
  assign w_above      = any_above(w_trig, w_fl);
  assign w_below      = any_below(w_trig, w_fl);
  assign w_hit_step   = at_floor(w_trig, w_fl_step);
  assign w_above_step = any_above(w_trig, w_fl_step);
  assign w_below_step = any_below(w_trig, w_fl_step);

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_nxt  = r_timer;
    w_pos_nxt    = r_pos;
    w_dir_nxt    = r_dir;
    w_served_nxt = '0;
    case (r_state)
      IDLE: begin
        // Decided every clk regardless of tick_en: current floor, then same direction, then reverse.
        w_timer_nxt = '0;
        if (w_here) begin
          w_state_nxt  = DWELL;
          w_served_nxt = NUM_FLOORS'(floor_onehot(w_fl));
        end else if ((r_dir && w_above) || (!r_dir && w_below)) begin
          w_state_nxt = MOVE;
        end else if (w_above) begin
          w_dir_nxt   = 1'b1;
          w_state_nxt = MOVE;
        end else if (w_below) begin
          w_dir_nxt   = 1'b0;
          w_state_nxt = MOVE;
        end
      end
      MOVE: begin
        if (i_tick_en) begin
          if (r_timer == STEP_LAST) begin
            w_timer_nxt = '0;
            w_pos_nxt   = w_pos_step;
            // Odd positions are between floors; only whole-floor arrivals are evaluated.
            if (!w_pos_step[0]) begin
              if (w_hit_step) begin
                w_state_nxt  = DWELL;
                w_served_nxt = NUM_FLOORS'(floor_onehot(w_fl_step));
              end else if (!(r_dir ? w_above_step : w_below_step)) begin
                w_state_nxt = IDLE;
              end
            end
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
      end
      DWELL: begin
        if (i_door_hold || w_here) begin
          w_timer_nxt = '0;
        end else if (i_tick_en) begin
          if (r_timer == DWELL_LAST) begin
            w_timer_nxt = '0;
            w_state_nxt = IDLE;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_timer  <= '0;
      r_pos    <= '0;
      r_dir    <= 1'b1;
      r_moving <= 1'b0;
      r_door   <= 1'b0;
      r_served <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_timer  <= w_timer_nxt;
      r_pos    <= w_pos_nxt;
      r_dir    <= w_dir_nxt;
      r_moving <= (w_state_nxt == MOVE);
      r_door   <= (w_state_nxt == DWELL);
      r_served <= w_served_nxt;
    end
  end

  assign o_half_pos  = r_pos;
  assign o_dir_up    = r_dir;
  assign o_moving    = r_moving;
  assign o_door_open = r_door;
  assign o_served    = r_served;

  a_pos_bounds: assert property (@(posedge clk) disable iff (rst) r_pos <= MAX_POS);

endmodule

// File: rtl/elevator_bank_scheduler.sv
// rtl/elevator_bank_scheduler.sv - bank of independent SCAN elevator cars
// Each car sees only its own slice of the destination/request buses; cars never interact.
module elevator_bank_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_CARS    = 2,
  parameter int NUM_FLOORS  = DEF_NUM_FLOORS,
  parameter int STEP_TICKS  = DEF_STEP_TICKS,
  parameter int DWELL_TICKS = DEF_DWELL_TICKS,
  localparam int POS_W      = $clog2(2*NUM_FLOORS-1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           tick_en,
  input  logic [NUM_CARS*NUM_FLOORS-1:0] floor_dest,
  input  logic [NUM_CARS*NUM_FLOORS-1:0] floor_req,
  input  logic [NUM_CARS-1:0]            door_hold,
  output logic [NUM_CARS*POS_W-1:0]      half_pos,
  output logic [NUM_CARS-1:0]            dir_up,
  output logic [NUM_CARS-1:0]            moving,
  output logic [NUM_CARS-1:0]            door_open,
  output logic [NUM_CARS*NUM_FLOORS-1:0] served
);

  for (genvar c = 0; c < NUM_CARS; c++) begin : g_car
    logic [NUM_FLOORS-1:0] w_trig;

    assign w_trig = floor_dest[c*NUM_FLOORS +: NUM_FLOORS] | floor_req[c*NUM_FLOORS +: NUM_FLOORS];

    elevator_car_fsm #(
      .NUM_FLOORS  (NUM_FLOORS),
      .STEP_TICKS  (STEP_TICKS),
      .DWELL_TICKS (DWELL_TICKS)
    ) u_car (
      .clk         (clk),
      .rst         (rst),
      .i_tick_en   (tick_en),
      .i_trig      (w_trig),
      .i_door_hold (door_hold[c]),
      .o_half_pos  (half_pos[c*POS_W +: POS_W]),
      .o_dir_up    (dir_up[c]),
      .o_moving    (moving[c]),
      .o_door_open (door_open[c]),
      .o_served    (served[c*NUM_FLOORS +: NUM_FLOORS])
    );
  end

endmodule
